// File: rtl/axi_pkg.sv
// Shared AXI3 types for the SRAM responder: burst/response encodings, FSM states and
// the burst legality rule used by both the address generator and the read-request path.
package axi_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'd0,
        BurstIncr  = 2'd1,
        BurstWrap  = 2'd2,
        BurstRsvd  = 2'd3
    } burst_t;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespExokay = 2'b01,
        RespSlverr = 2'b10,
        RespDecerr = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        StWIdle,
        StWData,
        StWResp
    } w_state_e;

    typedef enum logic {
        StRIdle,
        StRData
    } r_state_e;

    // Reserved bursts are illegal; WRAP needs len+1 to be a power of two of at least 2.
    function automatic logic burst_err(input logic [7:0] len, input burst_t burst);
        return (burst == BurstRsvd) ||
               ((burst == BurstWrap) && ((len == 8'd0) || ((len & (len + 8'd1)) != 8'd0)));
    endfunction

endpackage

// File: rtl/axi.sv
// AXI3 channel bundle with initiator- and peripheral-side views.
interface axi #(
    parameter int unsigned ADDR_ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BURST_LEN_WIDTH = 4
) (
    input logic aclk,
    input logic areset_n
);

    logic [ADDR_ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0]      awaddr;
    logic [BURST_LEN_WIDTH-1:0] awlen;
    logic [2:0]                 awsize;
    logic [1:0]                 awburst;
    logic [1:0]                 awlock;
    logic [3:0]                 awcache;
    logic [2:0]                 awprot;
    logic                       awvalid;
    logic                       awready;

    logic [DATA_WIDTH-1:0]      wdata;
    logic [DATA_WIDTH/8-1:0]    wstrb;
    logic                       wlast;
    logic                       wvalid;
    logic                       wready;

    logic [ADDR_ID_WIDTH-1:0]   bid;
    logic [1:0]                 bresp;
    logic                       bvalid;
    logic                       bready;

    logic [ADDR_ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0]      araddr;
    logic [BURST_LEN_WIDTH-1:0] arlen;
    logic [2:0]                 arsize;
    logic [1:0]                 arburst;
    logic [1:0]                 arlock;
    logic [3:0]                 arcache;
    logic [2:0]                 arprot;
    logic                       arvalid;
    logic                       arready;

    logic [ADDR_ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0]      rdata;
    logic [1:0]                 rresp;
    logic                       rlast;
    logic                       rvalid;
    logic                       rready;

    modport initiator_modport (
        input  aclk, areset_n,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport peripheral_modport (
        input  aclk, areset_n,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat word index for FIXED/INCR/WRAP bursts, plus burst legality.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned IDX_WIDTH = 6,
    parameter int unsigned LEN_WIDTH = 4
) (
    input  logic [IDX_WIDTH-1:0] idx_i,
    input  logic [LEN_WIDTH-1:0] len_i,
    input  burst_t               burst_i,
    output logic [IDX_WIDTH-1:0] next_idx_o,
    output logic                 burst_err_o
);

    logic [IDX_WIDTH-1:0] wrap_mask;
    logic [IDX_WIDTH-1:0] idx_inc;

    // Next index: INCR wraps at the index width, WRAP stays inside the len-aligned window.
    always_comb begin
        wrap_mask = '0;
        wrap_mask[LEN_WIDTH-1:0] = len_i;
        idx_inc = idx_i + IDX_WIDTH'(1);
        case (burst_i)
            BurstIncr: next_idx_o = idx_inc;
            BurstWrap: next_idx_o = (idx_i & ~wrap_mask) | (idx_inc & wrap_mask);
            default:   next_idx_o = idx_i;
        endcase
        burst_err_o = burst_err(8'(len_i), burst_i);
    end

endmodule

// File: rtl/axi_sram_responder.sv
// AXI3 peripheral backed by a word-addressed register-file memory. Independent write
// (AW/W/B) and read (AR/R) FSMs; errored beats never touch memory and read back as zero.
module axi_sram_responder
    import axi_pkg::*;
#(
    parameter int unsigned ADDR_ID_WIDTH   = 1,
    parameter int unsigned ADDR_WIDTH      = 8,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned BURST_LEN_WIDTH = 4,
    parameter int unsigned DEPTH           = 32
) (
    input logic              aclk,
    input logic              areset,
    axi.peripheral_modport   s
);

    localparam int unsigned ByteLanes = DATA_WIDTH / 8;
    localparam int unsigned OffWidth  = $clog2(ByteLanes);
    localparam int unsigned IdxWidth  = ADDR_WIDTH - OffWidth;
    localparam int unsigned MemAw     = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write channel state
    w_state_e                   w_state_q;
    logic                       awready_q, wready_q, bvalid_q;
    logic [ADDR_ID_WIDTH-1:0]   aw_id_q, bid_q;
    resp_t                      bresp_q;
    logic [IdxWidth-1:0]        w_idx_q, w_next_idx;
    logic [BURST_LEN_WIDTH-1:0] w_len_q, w_cnt_q;
    burst_t                     w_burst_q;
    logic                       w_err_q, w_gen_err, w_last_beat, w_beat_err, w_fire;

    // Read channel state
    r_state_e                   r_state_q;
    logic                       arready_q, rvalid_q, rlast_q;
    logic [ADDR_ID_WIDTH-1:0]   rid_q;
    resp_t                      rresp_q;
    logic [DATA_WIDTH-1:0]      rdata_q;
    logic [IdxWidth-1:0]        r_idx_q, r_next_idx, ar_idx;
    logic [BURST_LEN_WIDTH-1:0] r_len_q, r_cnt_q, r_cnt_inc;
    burst_t                     r_burst_q;
    logic                       r_gen_err, r_next_err, ar_err;

    axi_burst_addr_gen #(
        .IDX_WIDTH (IdxWidth),
        .LEN_WIDTH (BURST_LEN_WIDTH)
    ) u_w_addr_gen (
        .idx_i       (w_idx_q),
        .len_i       (w_len_q),
        .burst_i     (w_burst_q),
        .next_idx_o  (w_next_idx),
        .burst_err_o (w_gen_err)
    );

    axi_burst_addr_gen #(
        .IDX_WIDTH (IdxWidth),
        .LEN_WIDTH (BURST_LEN_WIDTH)
    ) u_r_addr_gen (
        .idx_i       (r_idx_q),
        .len_i       (r_len_q),
        .burst_i     (r_burst_q),
        .next_idx_o  (r_next_idx),
        .burst_err_o (r_gen_err)
    );

    // Per-beat error qualification; the last beat is the counted one, wlast only cross-checks it.
    always_comb begin
        w_fire      = s.wvalid & wready_q;
        w_last_beat = (w_cnt_q == w_len_q);
        w_beat_err  = w_gen_err | (32'(w_idx_q) >= DEPTH) | (s.wlast != w_last_beat);
        ar_idx      = s.araddr[ADDR_WIDTH-1:OffWidth];
        ar_err      = burst_err(8'(s.arlen), burst_t'(s.arburst)) | (32'(ar_idx) >= DEPTH);
        r_next_err  = r_gen_err | (32'(r_next_idx) >= DEPTH);
        r_cnt_inc   = r_cnt_q + BURST_LEN_WIDTH'(1);
    end

    // Byte-strobed memory write; contents survive reset.
    always_ff @(posedge aclk) begin
        if (!areset && w_fire && !w_beat_err) begin
            for (int unsigned b = 0; b < ByteLanes; b++) begin
                if (s.wstrb[b]) begin
                    mem_q[w_idx_q[MemAw-1:0]][8*b +: 8] <= s.wdata[8*b +: 8];
                end
            end
        end
    end

    // Write FSM: AW capture, W beats, then hold B until accepted.
    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q <= StWIdle;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= RespOkay;
            aw_id_q   <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_burst_q <= BurstFixed;
            w_err_q   <= 1'b0;
        end else begin
            case (w_state_q)
                StWIdle: begin
                    awready_q <= 1'b1;
                    if (s.awvalid && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        aw_id_q   <= s.awid;
                        w_idx_q   <= s.awaddr[ADDR_WIDTH-1:OffWidth];
                        w_len_q   <= s.awlen;
                        w_burst_q <= burst_t'(s.awburst);
                        w_cnt_q   <= '0;
                        w_err_q   <= 1'b0;
                        w_state_q <= StWData;
                    end
                end
                StWData: begin
                    if (w_fire) begin
                        w_idx_q <= w_next_idx;
                        w_cnt_q <= w_cnt_q + BURST_LEN_WIDTH'(1);
                        w_err_q <= w_err_q | w_beat_err;
                        if (w_last_beat) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bid_q     <= aw_id_q;
                            bresp_q   <= (w_err_q | w_beat_err) ? RespSlverr : RespOkay;
                            w_state_q <= StWResp;
                        end
                    end
                end
                StWResp: begin
                    if (s.bready) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= StWIdle;
                    end
                end
                default: w_state_q <= StWIdle;
            endcase
        end
    end

    // Read FSM: AR capture preloads beat 0; each accepted non-last beat preloads the next.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state_q <= StRIdle;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= RespOkay;
            rdata_q   <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_burst_q <= BurstFixed;
        end else begin
            case (r_state_q)
                StRIdle: begin
                    arready_q <= 1'b1;
                    if (s.arvalid && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= s.arid;
                        r_idx_q   <= ar_idx;
                        r_len_q   <= s.arlen;
                        r_burst_q <= burst_t'(s.arburst);
                        r_cnt_q   <= '0;
                        rlast_q   <= (s.arlen == '0);
                        rresp_q   <= ar_err ? RespSlverr : RespOkay;
                        rdata_q   <= ar_err ? '0 : mem_q[ar_idx[MemAw-1:0]];
                        r_state_q <= StRData;
                    end
                end
                StRData: begin
                    if (s.rready) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= StRIdle;
                        end else begin
                            r_idx_q <= r_next_idx;
                            r_cnt_q <= r_cnt_inc;
                            rlast_q <= (r_cnt_inc == r_len_q);
                            rresp_q <= r_next_err ? RespSlverr : RespOkay;
                            rdata_q <= r_next_err ? '0 : mem_q[r_next_idx[MemAw-1:0]];
                        end
                    end
                end
                default: r_state_q <= StRIdle;
            endcase
        end
    end

    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = bvalid_q;
    assign s.bid     = bid_q;
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = rvalid_q;
    assign s.rlast   = rlast_q;
    assign s.rid     = rid_q;
    assign s.rresp   = rresp_q;
    assign s.rdata   = rdata_q;

    // Bundle fields this responder deliberately ignores.
    logic unused_sig;
    assign unused_sig = ^{s.aclk, s.areset_n, s.awaddr, s.awsize, s.awlock, s.awcache,
                          s.awprot, s.araddr, s.arsize, s.arlock, s.arcache, s.arprot};

endmodule

// File: tb/tb_axi_sram_responder.sv
// Randomised and directed bench for axi_sram_responder against a word-array memory model.
module tb_axi_sram_responder;

    logic clk = 1'b0;
    logic areset = 1'b1;
    logic areset_n;
    assign areset_n = ~areset;
    always #5 clk = ~clk;

    axi #(
        .ADDR_ID_WIDTH   (1),
        .ADDR_WIDTH      (8),
        .DATA_WIDTH      (32),
        .BURST_LEN_WIDTH (4)
    ) bus (
        .aclk     (clk),
        .areset_n (areset_n)
    );

    axi_sram_responder #(
        .ADDR_ID_WIDTH   (1),
        .ADDR_WIDTH      (8),
        .DATA_WIDTH      (32),
        .BURST_LEN_WIDTH (4),
        .DEPTH           (32)
    ) dut (
        .aclk   (clk),
        .areset (areset),
        .s      (bus.peripheral_modport)
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] mem_m [32];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit burst_ok(int len, int burst);
        if (burst == 3) return 1'b0;
        if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
        return 1'b1;
    endfunction

    // Word index of the next beat, from the burst rules in plain arithmetic.
    function automatic int next_idx(int idx, int len, int burst);
        int n;
        int base;
        if (burst == 0) return idx;
        if (burst == 1) return (idx + 1) % 64;
        n = len + 1;
        base = idx - (idx % n);
        return base + ((idx + 1 - base) % n);
    endfunction

    task automatic init_bus();
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd2; bus.awburst = 2'd1;
        bus.awlock = '0; bus.awcache = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd2; bus.arburst = 2'd1;
        bus.arlock = '0; bus.arcache = '0; bus.arprot = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;
    endtask

    // bad_last: beat index whose wlast is inverted (-1 for none).
    task automatic do_write(input int id, input int addr, input int len, input int burst,
                            input int bad_last, input int gaps, input int bdelay,
                            input string name);
        int n;
        int idx;
        bit err_any;
        bit beat_err;
        bit stall_bad;
        logic [1:0] exp_b;
        @(negedge clk);
        bus.awid = id[0:0]; bus.awaddr = addr[7:0]; bus.awlen = len[3:0];
        bus.awburst = burst[1:0]; bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL %s aw_timeout: awready=%b want 1", name, bus.awready);
        end
        @(negedge clk);
        bus.awvalid = 1'b0;
        checks++;
        if (bus.wready !== 1'b1 || bus.awready !== 1'b0) begin
            errors++;
            $display("FAIL %s aw_latency: wready=%b awready=%b want 1 0", name, bus.wready,
                     bus.awready);
        end
        idx = (addr >> 2) % 64;
        err_any = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps != 0 && $urandom_range(0, 1) == 1) begin
                bus.wvalid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            bus.wdata = wd[i]; bus.wstrb = ws[i];
            bus.wlast = (i == len) ^ (i == bad_last); bus.wvalid = 1'b1;
            beat_err = !burst_ok(len, burst) || idx >= 32 || (bus.wlast != (i == len));
            if (!beat_err) begin
                for (int b = 0; b < 4; b++) if (ws[i][b]) mem_m[idx][8*b +: 8] = wd[i][8*b +: 8];
            end
            err_any |= beat_err;
            idx = next_idx(idx, len, burst);
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        exp_b = err_any ? 2'b10 : 2'b00;
        checks++;
        if (bus.bvalid !== 1'b1 || bus.wready !== 1'b0) begin
            errors++;
            $display("FAIL %s b_latency: bvalid=%b wready=%b want 1 0", name, bus.bvalid,
                     bus.wready);
        end
        stall_bad = 1'b0;
        for (int k = 0; k < bdelay; k++) begin
            if (bus.bvalid !== 1'b1 || bus.bresp !== exp_b || bus.bid !== id[0:0]) stall_bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (stall_bad) begin
            errors++;
            $display("FAIL %s b_stall: bvalid=%b bresp=%0d want 1 %0d held", name, bus.bvalid,
                     bus.bresp, exp_b);
        end
        checks++;
        if (bus.bresp !== exp_b || bus.bid !== id[0:0]) begin
            errors++;
            $display("FAIL %s bresp: bresp=%0d bid=%0d want %0d %0d", name, bus.bresp, bus.bid,
                     exp_b, id);
        end
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        checks++;
        if (bus.bvalid !== 1'b0 || bus.awready !== 1'b1) begin
            errors++;
            $display("FAIL %s b_done: bvalid=%b awready=%b want 0 1", name, bus.bvalid,
                     bus.awready);
        end
    endtask

    // rmode: 0 always ready, 1 ready every other cycle, 2 random ready.
    task automatic do_read(input int id, input int addr, input int len, input int burst,
                           input int rmode, input string name);
        logic [31:0] exp_d [16];
        logic [1:0]  exp_r [16];
        int idx;
        int n;
        int beat;
        int cyc;
        bit rr;
        bit err;
        idx = (addr >> 2) % 64;
        for (int i = 0; i <= len; i++) begin
            err = !burst_ok(len, burst) || idx >= 32;
            exp_d[i] = err ? 32'h0 : mem_m[idx];
            exp_r[i] = err ? 2'b10 : 2'b00;
            idx = next_idx(idx, len, burst);
        end
        @(negedge clk);
        bus.arid = id[0:0]; bus.araddr = addr[7:0]; bus.arlen = len[3:0];
        bus.arburst = burst[1:0]; bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        checks++;
        if (bus.rvalid !== 1'b1 || bus.arready !== 1'b0) begin
            errors++;
            $display("FAIL %s ar_latency: rvalid=%b arready=%b want 1 0", name, bus.rvalid,
                     bus.arready);
        end
        beat = 0;
        cyc = 0;
        while (beat <= len && cyc < 200) begin
            rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            bus.rready = rr;
            if (bus.rvalid === 1'b1) begin
                checks++;
                if (bus.rdata !== exp_d[beat] || bus.rresp !== exp_r[beat] ||
                    bus.rlast !== (beat == len) || bus.rid !== id[0:0]) begin
                    errors++;
                    $display("FAIL %s beat%0d%s: rdata=%h rresp=%0d rlast=%b rid=%0d want %h %0d %b %0d",
                             name, beat, rr ? "" : "_stall", bus.rdata, bus.rresp, bus.rlast,
                             bus.rid, exp_d[beat], exp_r[beat], beat == len, id);
                end
                if (rr) beat++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.rready = 1'b0;
        checks++;
        if (beat != len + 1 || bus.arready !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s r_done: beats=%0d arready=%b rvalid=%b want %0d 1 0", name, beat,
                     bus.arready, bus.rvalid, len + 1);
        end
    endtask

    task automatic test_reset();
        init_bus();
        areset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast, bus.bid,
             bus.rid, bus.bresp, bus.rresp, bus.rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: aw=%b w=%b b=%b ar=%b r=%b rdata=%h want all 0",
                     bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata);
        end
        areset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: awready=%b arready=%b want 1 1", bus.awready,
                     bus.arready);
        end
    endtask

    task automatic test_init_mem();
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
            do_write(h, h * 64, 15, 1, -1, 0, 0, "init_wr");
        end
        do_read(0, 0, 15, 1, 0, "init_rd");
    endtask

    task automatic test_incr();
        for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
        do_write(1, 'h10, 3, 1, -1, 0, 0, "incr_wr");
        do_read(1, 'h10, 3, 1, 0, "incr_rd");
    endtask

    task automatic test_strobes();
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(0, 'h00, 0, 1, -1, 0, 0, "strb_wr_full");
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'h5;
        do_write(0, 'h00, 0, 1, -1, 0, 0, "strb_wr_part");
        do_read(0, 'h00, 0, 1, 0, "strb_rd");
    endtask

    task automatic test_wrap();
        do_read(1, 'h18, 3, 2, 1, "wrap_rd");
        do_read(0, 'h18, 2, 2, 0, "wrap_badlen_rd");
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(0, 'h30, 1, 3, -1, 0, 0, "rsvd_wr");
        do_read(0, 'h30, 1, 1, 0, "rsvd_check_rd");
    endtask

    task automatic test_out_of_range();
        for (int i = 0; i < 2; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(1, 'h7C, 1, 1, -1, 0, 0, "oor_wr");
        do_read(1, 'h80, 0, 1, 0, "oor_rd");
        do_read(0, 'h7C, 1, 1, 2, "oor_edge_rd");
    endtask

    task automatic test_wlast();
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(0, 'h20, 3, 1, 3, 0, 0, "wlast_missing_wr");
        for (int i = 0; i < 4; i++) begin wd[i] = $urandom; ws[i] = 4'hF; end
        do_write(1, 'h30, 3, 1, 1, 1, 0, "wlast_early_wr");
        do_read(0, 'h20, 7, 1, 0, "wlast_rd");
    endtask

    task automatic test_random();
        int len;
        int burst;
        int addr;
        for (int it = 0; it < 25; it++) begin
            burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            len = $urandom_range(0, 15);
            if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            addr = $urandom_range(0, 39) * 4 + $urandom_range(0, 3);
            for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
            do_write($urandom_range(0, 1), addr, len, burst,
                     ($urandom_range(0, 7) == 0) ? $urandom_range(0, len) : -1,
                     $urandom_range(0, 1), $urandom_range(0, 3), "rand_wr");
            burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            len = $urandom_range(0, 15);
            if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            addr = $urandom_range(0, 39) * 4 + $urandom_range(0, 3);
            do_read($urandom_range(0, 1), addr, len, burst, $urandom_range(0, 2), "rand_rd");
        end
    endtask

    task automatic test_concurrency();
        for (int i = 0; i < 8; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom); end
        fork
            do_write(1, 'h50, 7, 1, -1, 1, 5, "conc_wr");
            do_read(0, 'h00, 7, 1, 1, "conc_rd");
        join
        do_read(1, 'h50, 7, 1, 0, "conc_check_rd");
    endtask

    task automatic test_reset_mid_burst();
        int n;
        @(negedge clk);
        bus.awid = 1'b1; bus.awaddr = 8'h40; bus.awlen = 4'd3; bus.awburst = 2'd1;
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.wdata = $urandom; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
            mem_m[16 + i] = bus.wdata;
            @(negedge clk);
        end
        bus.wvalid = 1'b0;
        bus.arid = 1'b0; bus.araddr = 8'h00; bus.arlen = 4'd7; bus.arburst = 2'd1;
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== mem_m[2] || bus.rlast !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_beat2: rvalid=%b rdata=%h rlast=%b want 1 %h 0", bus.rvalid,
                     bus.rdata, bus.rlast, mem_m[2]);
        end
        areset = 1'b1;
        bus.rready = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rlast, bus.bid,
             bus.rid, bus.bresp, bus.rresp, bus.rdata} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: aw=%b w=%b b=%b ar=%b r=%b rdata=%h want all 0",
                     bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.rdata);
        end
        areset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.arready !== 1'b1 || bus.awready !== 1'b1 || bus.rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: arready=%b awready=%b rvalid=%b want 1 1 0",
                     bus.arready, bus.awready, bus.rvalid);
        end
        do_read(0, 'h40, 3, 1, 0, "rst_mid_after_rd");
    endtask

    initial begin
        test_reset();
        test_init_mem();
        test_incr();
        test_strobes();
        test_wrap();
        test_out_of_range();
        test_wlast();
        test_random();
        test_concurrency();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_sram_responder.md
# axi_sram_responder

AXI3 responder (slave) that backs the peripheral side of the `axi` interface bundle with an internal word-addressed register-file memory. It accepts write bursts (AW/W/B) and read bursts (AR/R) on independent state machines, with FIXED, INCR and WRAP addressing and byte strobes. It is the memory endpoint for initiator-side bring-up and the reference target for bus-level verification.

## Interface

- `ADDR_ID_WIDTH`, 1: AW/AR ID width; must match the bundle.
- `ADDR_WIDTH`, 8: byte address width; must match the bundle.
- `DATA_WIDTH`, 32: data width, a power of two ≥ 8; must match the bundle.
- `BURST_LEN_WIDTH`, 4: burst length width, giving a maximum of 16 beats.
- `DEPTH`, 32: memory depth in words.
- `aclk`  input  1  clock; every register updates on its rising edge.
- `areset`  input  1  reset; synchronous and active-high.
- `s`  modport  `axi.peripheral_modport`  carries the AXI3 channels. The bundle's own `aclk`/`areset_n` are not used. `awlock`/`awcache`/`awprot`/`arlock`/`arcache`/`arprot` are ignored.

## Operation

- **Transfer size.** Only full-width transfers are supported and `awsize` is ignored. Word index = byte address >> log2(`DATA_WIDTH`/8); the low address bits are ignored.
- **Write FSM.**
  - `W_IDLE`: `awready`=1. On an AW handshake, capture `awid`, index, `awlen` and `awburst`, clear the beat counter, and go to `W_DATA`.
  - `W_DATA`: `wready`=1. On each W handshake, write the bytes of `wdata` whose `wstrb` bit is set into the current word, then advance the address.
  - The beat where counter == `awlen` ends the burst and moves to `W_RESP`, whether or not `wlast` is asserted.
  - `W_RESP`: `bvalid`=1, `bid`=captured ID. On a B handshake, return to `W_IDLE`.
- **Read FSM.**
  - `R_IDLE`: `arready`=1. On an AR handshake, capture the request, load the `rdata` register with word 0, and go to `R_DATA`.
  - `R_DATA`: `rvalid`=1, `rid`=captured ID, `rlast` = (counter == `arlen`). On each R handshake that is not the last beat, advance the address and load the next word. After the last beat, return to `R_IDLE`.
- **Address generation.**
  - FIXED (0): the index is unchanged between beats.
  - INCR (1): index+1, modulo 2^(index width).
  - WRAP (2): with mask = len, index = (index & ~mask) | ((index+1) & mask).
- **Response codes.** Constants are OKAY=2'b00 and SLVERR=2'b10.
  - SLVERR applies to: burst type 3; WRAP with a length not in {1,3,7,15}; any beat whose index ≥ `DEPTH`; a write whose `wlast` disagrees with the counted last beat.
- **Errored beats.** Errored write beats leave memory unchanged. Errored read beats return `rdata`=0 with `rresp`=SLVERR. Bad burst type or bad WRAP length errors every beat.
- **Write response.** `bresp` is SLVERR if any beat of the burst errored; otherwise OKAY.
- **Read/write concurrency.** The two channels run concurrently. A read load and a write to the same word on the same edge: the read gets the old data.

## Timing

- **Reset.** While `areset` is high, all FSMs go to IDLE, all counters clear, and `awready`, `wready`, `bvalid`, `arready`, `rvalid`, `rlast`, `bid`, `rid`, `bresp`, `rresp` and `rdata` are all 0. Memory contents are not reset.
- **After reset.** `awready`=`arready`=1 in the first cycle after `areset` falls.
- **Reset mid-burst** aborts the transaction with no response. Beats already written stay written.
- **Write latency.** `wready` rises the cycle after the AW handshake. `bvalid` rises the cycle after the last W beat. `awready` is 0 from the AW handshake until the cycle after the B handshake.
- **Read latency.** `rvalid` rises the cycle after the AR handshake. Beats are back-to-back while `rready`=1. `arready` is 0 until the cycle after the last R handshake.
- **Handshake rules.** Once asserted, `bvalid`/`rvalid` and their payloads hold until the handshake. Ready signals never depend combinationally on valid.

## Structure

- Package `axi_pkg` holds:
  - the `burst_t` enum (FIXED/INCR/WRAP/RSVD);
  - the `resp_t` constants OKAY/EXOKAY/SLVERR/DECERR;
  - the write/read state enums.
- Sub-module `axi_burst_addr_gen` is purely combinational. It maps current index, len and burst to the next index plus a burst-error flag. It is instantiated twice, once for writes and once for reads.

## Test plan

1. **INCR write then read.** AW addr 0x10, len 3, INCR; W data 0xA0..0xA3, strobe 0xF. Expect B OKAY, bid = awid. AR 0x10, len 3 → R 0xA0, 0xA1, 0xA2, 0xA3, with `rlast` only on beat 4, all OKAY.
2. **Strobes.** Write 0x11223344 to 0x00 with strb 0xF, then write 0xFFFFFFFF with strb 0x5. Reading 0x00 returns 0x11FF33FF.
3. **WRAP.** Read AR 0x18, len 3, WRAP → words 6, 7, 4, 5. WRAP with len 2 → 3 beats of SLVERR with `rdata`=0.
4. **Out of range.** INCR write at 0x7C, len 1 → word 31 written, word 32 dropped, bresp SLVERR. Read at 0x80 → SLVERR with 0 data.
5. **Concurrency and backpressure.** A read burst and a write burst run overlapped, with `rready` toggled every other cycle and `bready` delayed 5 cycles. Payloads must stay stable while stalled, with no lost or duplicated beats.
6. **Reset mid-burst.** Assert `areset` during beat 2 of a len-7 read. All outputs are 0 next cycle, `arready`=1 the cycle after release, and a new AR completes normally.
